zeroheti_obi_arbiter: RTL and testbench
=======================================

// Module: zeroheti_obi_arbiter
// PURPOSE
// - N:1 round-robin OBI arbiter sharing one OBI subordinate (dmem SRAM, or the APB bridge port) between core data, debug SBA and future DMA managers.
// - Tracks in-flight requests per owner and routes each response back to its issuing manager in order.
// - Sits between crossbar subordinate ports and a single-ported target; zero-latency request path, no data buffering.
// PARAMETERS
// - NumMgr    2   number of requesting managers (>=2)
// - MaxTrans  2   max outstanding granted-but-unresponded transactions (>=1)
// - AddrW     32  address width
// - DataW     32  data width; byte-enable width = DataW/8
// PORTS
// - clk_i         in   1            clock
// - rst_ni        in   1            async active-low reset
// - mgr_req_i     in   NumMgr       request per manager
// - mgr_addr_i    in   NumMgr*AddrW address per manager
// - mgr_we_i      in   NumMgr       write enable per manager
// - mgr_be_i      in   NumMgr*DataW/8  byte enables
// - mgr_wdata_i   in   NumMgr*DataW write data
// - mgr_lock_i    in   NumMgr       hold ownership (only with ZEROHETI_OBI_ARB_LOCK_EN)
// - mgr_gnt_o     out  NumMgr       grant, one-hot or zero
// - mgr_rvalid_o  out  NumMgr       response valid, one-hot or zero
// - mgr_rdata_o   out  DataW        read data, broadcast
// - mgr_err_o     out  1            response error, broadcast
// - sbr_req_o / sbr_addr_o / sbr_we_o / sbr_be_o / sbr_wdata_o  out  1/AddrW/1/DataW/8/DataW  muxed request to target
// - sbr_gnt_i     in   1            target grant
// - sbr_rvalid_i  in   1            target response valid
// - sbr_rdata_i   in   DataW        target read data
// - sbr_err_i     in   1            target error
// BEHAVIOUR
// - Reset (async, rst_ni=0): rr pointer=0, FIFO empty, lock owner cleared; all outputs 0 while in reset.
// - Selection (combinational): first requesting manager searching from rr pointer upward, wrapping at NumMgr.
// - sbr_req_o = any mgr_req_i && !fifo_full; sbr_addr_o/we/be/wdata = selected manager's fields (0 when no request).
// - mgr_gnt_o[sel] = sbr_gnt_i && sbr_req_o; same-cycle combinational, zero added latency.
// - Handshake (sbr_req_o && sbr_gnt_i): push sel into in-order ID FIFO; rr pointer <= (sel+1) mod NumMgr.
// - Response: on sbr_rvalid_i, pop FIFO head h; mgr_rvalid_o[h]=1, all other bits 0; rdata/err passed through combinationally.
// - Full: fifo count==MaxTrans forces sbr_req_o=0; a same-cycle pop does not unblock a push. Next handshake is possible one cycle later.
// - Empty + sbr_rvalid_i: protocol violation. Response dropped, all rvalid 0; simulation assertion fires (guarded by `ifndef SYNTHESIS).
// - Simultaneous push and pop (not full): count unchanged, both take effect.
// - Manager deasserting req before gnt: legal, no state change; selection re-evaluates next cycle.
// - Reset mid-transaction: FIFO cleared. Responses arriving after reset fall under the empty rule and are dropped.
// - Count width $clog2(MaxTrans+1); pointer/ID width IdxW=$clog2(NumMgr), with mod-NumMgr wrap for non-power-of-2.
// CONFIGURATION
// - Macro ZEROHETI_OBI_ARB_LOCK_EN defined:
//   - A manager granted while mgr_lock_i high becomes lock owner.
//   - Only the owner is selectable until it issues a handshake with mgr_lock_i low, or until rst_ni.
//   - The rr pointer is not advanced while locked.
//   - Used for atomic read-modify-write from debug SBA.
// - Macro undefined: mgr_lock_i is absent from the port list; pure round-robin.
// STRUCTURE
// - zeroheti_pkg gains: obi_arb_idx_t helper function clog2-safe (min 1 bit), and localparams DefaultArbMgrs=2, DefaultArbTrans=2.
// - Sub-module zeroheti_id_fifo: sync FIFO with params Depth and Width.
//   - Ports: push/pop/data_in/head/full/empty/count.
//   - Holds response-owner IDs. The arbiter top holds rr/lock logic and the mux.
// TESTING
// - Reset, then mgr_req_i=2'b11 held with sbr_gnt_i=1 every cycle -> grants alternate 01,10,01 starting at mgr0. rvalid routed in the same order.
// - MaxTrans=2, sbr_gnt_i=1, sbr_rvalid_i=0 -> exactly 2 grants, then sbr_req_o=0. One rvalid -> sbr_req_o=1 the following cycle.
// - Mgr0 read 0x1000, mgr1 write 0x1004 granted back-to-back; responses return 2 and 4 cycles later -> mgr_rvalid_o=01 then 10, rdata matches 0x1000 contents.
// - sbr_rvalid_i pulse with empty FIFO -> all mgr_rvalid_o stay 0, assertion reported, arbiter continues normally.
// - rst_ni pulled low with 2 outstanding -> outputs 0 immediately. After release, FIFO empty and the first grant goes to mgr0.
// - With ZEROHETI_OBI_ARB_LOCK_EN: mgr1 locks for 3 handshakes while mgr0 requests continuously -> mgr0 gets no grant until mgr1's unlocked handshake, then mgr0 is granted next.

Source files
------------

// File: rtl/zeroheti_pkg.sv
// Shared types and constants for the zeroheti OBI arbiter slice.
package zeroheti_pkg;

   localparam int unsigned DefaultArbMgrs  = 2;
   localparam int unsigned DefaultArbTrans = 2;

   typedef enum logic {
      LOCK_IDLE,
      LOCK_HELD
   } obi_arb_lock_e;

   // Index width for n entries; never collapses to zero bits when n == 1.
   function automatic int unsigned obi_arb_idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/zeroheti_obi_arbiter_if.sv
// Signal bundle between the managers, the arbiter and the shared OBI target.
// mgr_lock_i exists only when ZEROHETI_OBI_ARB_LOCK_EN is defined.
interface zeroheti_obi_arbiter_if #(
   parameter int unsigned NumMgr = zeroheti_pkg::DefaultArbMgrs,
   parameter int unsigned AddrW  = 32,
   parameter int unsigned DataW  = 32
);
   localparam int unsigned BeW = DataW / 8;

   logic [NumMgr-1:0]       mgr_req_i;
   logic [NumMgr*AddrW-1:0] mgr_addr_i;
   logic [NumMgr-1:0]       mgr_we_i;
   logic [NumMgr*BeW-1:0]   mgr_be_i;
   logic [NumMgr*DataW-1:0] mgr_wdata_i;
`ifdef ZEROHETI_OBI_ARB_LOCK_EN
   logic [NumMgr-1:0]       mgr_lock_i;
`endif
   logic [NumMgr-1:0]       mgr_gnt_o;
   logic [NumMgr-1:0]       mgr_rvalid_o;
   logic [DataW-1:0]        mgr_rdata_o;
   logic                    mgr_err_o;

   logic                    sbr_req_o;
   logic [AddrW-1:0]        sbr_addr_o;
   logic                    sbr_we_o;
   logic [BeW-1:0]          sbr_be_o;
   logic [DataW-1:0]        sbr_wdata_o;
   logic                    sbr_gnt_i;
   logic                    sbr_rvalid_i;
   logic [DataW-1:0]        sbr_rdata_i;
   logic                    sbr_err_i;

   // Arbiter view.
   modport slave (
      input  mgr_req_i, mgr_addr_i, mgr_we_i, mgr_be_i, mgr_wdata_i,
`ifdef ZEROHETI_OBI_ARB_LOCK_EN
      input  mgr_lock_i,
`endif
      output mgr_gnt_o, mgr_rvalid_o, mgr_rdata_o, mgr_err_o,
      output sbr_req_o, sbr_addr_o, sbr_we_o, sbr_be_o, sbr_wdata_o,
      input  sbr_gnt_i, sbr_rvalid_i, sbr_rdata_i, sbr_err_i
   );

   // Environment view: managers plus the shared target.
   modport master (
      output mgr_req_i, mgr_addr_i, mgr_we_i, mgr_be_i, mgr_wdata_i,
`ifdef ZEROHETI_OBI_ARB_LOCK_EN
      output mgr_lock_i,
`endif
      input  mgr_gnt_o, mgr_rvalid_o, mgr_rdata_o, mgr_err_o,
      input  sbr_req_o, sbr_addr_o, sbr_we_o, sbr_be_o, sbr_wdata_o,
      output sbr_gnt_i, sbr_rvalid_i, sbr_rdata_i, sbr_err_i
   );

endinterface

// File: rtl/zeroheti_id_fifo.sv
// In-order FIFO of response-owner IDs; push is ignored when full, pop when empty.
module zeroheti_id_fifo
   import zeroheti_pkg::*;
#(
   parameter int unsigned Depth = DefaultArbTrans,
   parameter int unsigned Width = 1
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           push_i,
   input  logic                           pop_i,
   input  logic [Width-1:0]               data_in_i,
   output logic [Width-1:0]               head_o,
   output logic                           full_o,
   output logic                           empty_o,
   output logic [$clog2(Depth+1)-1:0]     count_o
);

   localparam int unsigned PtrW = obi_arb_idx_w(Depth);
   localparam int unsigned CntW = $clog2(Depth + 1);

   typedef logic [PtrW-1:0] ptr_t;

   logic [Width-1:0] mem_q [Depth];
   ptr_t             wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]  count_q;
   logic             push_ok, pop_ok;

   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; an entry is never read before it is written.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_in_i;
   end

endmodule

// File: rtl/zeroheti_obi_arbiter.sv
// N:1 round-robin OBI arbiter with in-order response routing to the issuing manager.
// Defining ZEROHETI_OBI_ARB_LOCK_EN adds mgr_lock_i ownership for atomic sequences.
module zeroheti_obi_arbiter
   import zeroheti_pkg::*;
#(
   parameter int unsigned NumMgr   = DefaultArbMgrs,
   parameter int unsigned MaxTrans = DefaultArbTrans,
   parameter int unsigned AddrW    = 32,
   parameter int unsigned DataW    = 32
) (
   input logic                  clk_i,
   input logic                  rst_ni,
   zeroheti_obi_arbiter_if.slave bus
);

   localparam int unsigned IdxW = obi_arb_idx_w(NumMgr);
   localparam int unsigned CntW = $clog2(MaxTrans + 1);
   localparam int unsigned BeW  = DataW / 8;

   typedef logic [IdxW-1:0] idx_t;

   idx_t              rr_q, rr_d;
   idx_t              sel, fifo_head;
   int unsigned       sel_i;
   logic [NumMgr-1:0] req_mask, eligible;
   logic              any_req, sbr_req, handshake, advance, pop;
   logic              fifo_full, fifo_empty;
   logic [CntW-1:0]   fifo_count;

   function automatic idx_t wrap_idx(input idx_t base, input int unsigned off);
      logic [31:0] sum;
      sum = 32'(base) + off;
      return idx_t'(sum % NumMgr);
   endfunction

`ifdef ZEROHETI_OBI_ARB_LOCK_EN
   obi_arb_lock_e lock_state_q, lock_state_d;
   idx_t          lock_owner_q, lock_owner_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lock_state_q <= LOCK_IDLE;
         lock_owner_q <= '0;
      end else begin
         lock_state_q <= lock_state_d;
         lock_owner_q <= lock_owner_d;
      end
   end

   // Kept apart from the next-state process so the mask depends on registered state only.
   always_comb begin
      req_mask = '1;
      if (lock_state_q == LOCK_HELD) begin
         req_mask               = '0;
         req_mask[lock_owner_q] = 1'b1;
      end
   end

   always_comb begin
      lock_state_d = lock_state_q;
      lock_owner_d = lock_owner_q;
      unique case (lock_state_q)
         LOCK_IDLE: if (handshake && bus.mgr_lock_i[sel]) begin
            lock_state_d = LOCK_HELD;
            lock_owner_d = sel;
         end
         LOCK_HELD: if (handshake && !bus.mgr_lock_i[sel]) lock_state_d = LOCK_IDLE;
         default:   lock_state_d = LOCK_IDLE;
      endcase
   end

   assign advance = handshake && !bus.mgr_lock_i[sel];
`else
   assign req_mask = '1;
   assign advance  = handshake;
`endif

   assign eligible = bus.mgr_req_i & req_mask;

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      sel     = rr_q;
      any_req = 1'b0;
      for (int unsigned i = 0; i < NumMgr; i++) begin
         if (!any_req && eligible[wrap_idx(rr_q, i)]) begin
            any_req = 1'b1;
            sel     = wrap_idx(rr_q, i);
         end
      end
   end

   assign sel_i     = 32'(sel);
   assign sbr_req   = rst_ni && any_req && !fifo_full;
   assign handshake = sbr_req && bus.sbr_gnt_i;
   assign pop       = rst_ni && bus.sbr_rvalid_i && !fifo_empty;

   always_comb begin
      bus.sbr_req_o   = sbr_req;
      bus.sbr_addr_o  = '0;
      bus.sbr_we_o    = 1'b0;
      bus.sbr_be_o    = '0;
      bus.sbr_wdata_o = '0;
      if (rst_ni && any_req) begin
         bus.sbr_addr_o  = bus.mgr_addr_i[sel_i*AddrW +: AddrW];
         bus.sbr_we_o    = bus.mgr_we_i[sel_i];
         bus.sbr_be_o    = bus.mgr_be_i[sel_i*BeW +: BeW];
         bus.sbr_wdata_o = bus.mgr_wdata_i[sel_i*DataW +: DataW];
      end
   end

   always_comb begin
      bus.mgr_gnt_o    = '0;
      bus.mgr_rvalid_o = '0;
      if (handshake) bus.mgr_gnt_o[sel] = 1'b1;
      if (pop)       bus.mgr_rvalid_o[fifo_head] = 1'b1;
   end

   assign bus.mgr_rdata_o = rst_ni ? bus.sbr_rdata_i : '0;
   assign bus.mgr_err_o   = rst_ni && bus.sbr_err_i;

   assign rr_d = advance ? wrap_idx(sel, 1) : rr_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rr_q <= '0;
      else         rr_q <= rr_d;
   end

   zeroheti_id_fifo #(
      .Depth (MaxTrans),
      .Width (IdxW)
   ) u_id_fifo (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .push_i    (handshake),
      .pop_i     (pop),
      .data_in_i (sel),
      .head_o    (fifo_head),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .count_o   (fifo_count)
   );

`ifndef SYNTHESIS
   always @(posedge clk_i) begin
      if (rst_ni) begin
         assert (!(bus.sbr_rvalid_i && fifo_empty))
            else $warning("obi_arbiter: response with nothing outstanding, dropped");
         assert (fifo_full == (fifo_count == CntW'(MaxTrans)))
            else $error("obi_arbiter: id fifo count and full flag disagree");
      end
   end
`endif

endmodule

// File: tb/tb_zeroheti_obi_arbiter.sv
// Directed plus randomized bench for zeroheti_obi_arbiter against a queue-based model.
// Lock scenarios are exercised only when ZEROHETI_OBI_ARB_LOCK_EN is defined.
module tb_zeroheti_obi_arbiter;

   localparam int NM = 2;
   localparam int MT = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   zeroheti_obi_arbiter_if #(.NumMgr(NM), .AddrW(AW), .DataW(DW)) bus ();

   zeroheti_obi_arbiter #(
      .NumMgr(NM), .MaxTrans(MT), .AddrW(AW), .DataW(DW)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   // Stimulus values applied each step.
   logic [NM-1:0]    req_v, we_v, lock_v;
   logic [NM*AW-1:0] addr_v;
   logic [NM*BW-1:0] be_v;
   logic [NM*DW-1:0] wdata_v;
   logic             gnt_v, rv_v, err_v;
   logic [DW-1:0]    rdata_v;

   // Reference model: round-robin pointer, owner queue, lock owner (-1 = none).
   int m_rr;
   int m_q[$];
   int m_lock;

   int n_checks = 0;
   int n_errors = 0;

   logic [NM-1:0] obs_gnt, obs_rv;
   logic          obs_req;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      bus.mgr_req_i    = req_v;
      bus.mgr_addr_i   = addr_v;
      bus.mgr_we_i     = we_v;
      bus.mgr_be_i     = be_v;
      bus.mgr_wdata_i  = wdata_v;
`ifdef ZEROHETI_OBI_ARB_LOCK_EN
      bus.mgr_lock_i   = lock_v;
`endif
      bus.sbr_gnt_i    = gnt_v;
      bus.sbr_rvalid_i = rv_v;
      bus.sbr_rdata_i  = rdata_v;
      bus.sbr_err_i    = err_v;
   endtask

   task automatic idle();
      req_v = '0; we_v = '0; lock_v = '0; addr_v = '0; be_v = '0; wdata_v = '0;
      gnt_v = 1'b0; rv_v = 1'b0; err_v = 1'b0; rdata_v = '0;
   endtask

   function automatic int pick();
      for (int i = 0; i < NM; i++) begin
         int m;
         m = (m_rr + i) % NM;
         if (req_v[m] && (m_lock < 0 || m == m_lock)) return m;
      end
      return -1;
   endfunction

   // One clock: drive, check against the model, clock, update the model.
   task automatic step();
      int            s;
      logic          ereq;
      logic [NM-1:0] eg, er;
      drive();
      #1;
      s    = pick();
      ereq = (s >= 0) && (m_q.size() < MT);
      eg   = '0;
      er   = '0;
      if (ereq && gnt_v) eg[s] = 1'b1;
      if (rv_v && m_q.size() > 0) er[m_q[0]] = 1'b1;
      obs_req = bus.sbr_req_o;
      obs_gnt = bus.mgr_gnt_o;
      obs_rv  = bus.mgr_rvalid_o;
      check("sbr_req", bus.sbr_req_o, ereq);
      check("mgr_gnt", bus.mgr_gnt_o, eg);
      check("mgr_rvalid", bus.mgr_rvalid_o, er);
      if (s >= 0) begin
         check("sbr_addr", bus.sbr_addr_o, addr_v[s*AW +: AW]);
         check("sbr_we", bus.sbr_we_o, we_v[s]);
         check("sbr_be", bus.sbr_be_o, be_v[s*BW +: BW]);
         check("sbr_wdata", bus.sbr_wdata_o, wdata_v[s*DW +: DW]);
      end else begin
         check("sbr_addr_idle", bus.sbr_addr_o, 0);
         check("sbr_we_idle", bus.sbr_we_o, 0);
      end
      check("mgr_rdata", bus.mgr_rdata_o, rdata_v);
      check("mgr_err", bus.mgr_err_o, err_v);
      @(posedge clk);
      if (er != '0) void'(m_q.pop_front());
      if (ereq && gnt_v) begin
         m_q.push_back(s);
         if (m_lock < 0 && lock_v[s])       m_lock = s;
         else if (m_lock >= 0 && !lock_v[s]) m_lock = -1;
         if (!lock_v[s]) m_rr = (s + 1) % NM;
      end
      #1;
   endtask

   // Asserts reset with live traffic on the inputs; every output must read zero.
   task automatic apply_reset();
      req_v = '1; gnt_v = 1'b1; rv_v = 1'b1; err_v = 1'b1; rdata_v = 32'hA5A5_5A5A;
      addr_v = '1; we_v = '1; be_v = '1; wdata_v = '1;
      drive();
      rst_n = 1'b0;
      #1;
      check("rst_sbr_req", bus.sbr_req_o, 0);
      check("rst_gnt", bus.mgr_gnt_o, 0);
      check("rst_rvalid", bus.mgr_rvalid_o, 0);
      check("rst_addr", bus.sbr_addr_o, 0);
      check("rst_rdata", bus.mgr_rdata_o, 0);
      check("rst_err", bus.mgr_err_o, 0);
      repeat (2) @(posedge clk);
      #1;
      idle();
      drive();
      rst_n  = 1'b1;
      m_rr   = 0;
      m_lock = -1;
      m_q.delete();
   endtask

   task automatic drain();
      req_v = '0; gnt_v = 1'b0;
      for (int i = 0; i <= MT; i++) begin
         rv_v = (m_q.size() > 0);
         step();
      end
      rv_v = 1'b0;
      check("drained", m_q.size(), 0);
   endtask

   initial begin
      #200000;
      $error("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      idle();
      drive();
      apply_reset();

      // Round robin with both managers requesting; responses follow grant order.
      req_v = 2'b11; gnt_v = 1'b1; rv_v = 1'b0;
      step();
      check("rr_gnt0", obs_gnt, 2'b01);
      check("rr_rv0", obs_rv, 2'b00);
      rv_v = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         step();
         check("rr_gnt", obs_gnt, (k % 2) ? 2'b10 : 2'b01);
         check("rr_rv", obs_rv, (k % 2) ? 2'b01 : 2'b10);
      end
      drain();

      // Outstanding limit: two grants, then blocked; a same-cycle pop does not unblock.
      req_v = 2'b01; gnt_v = 1'b1; rv_v = 1'b0;
      step(); check("full_g1", obs_gnt, 2'b01);
      step(); check("full_g2", obs_gnt, 2'b01);
      step(); check("full_req", obs_req, 1'b0); check("full_gnt", obs_gnt, 2'b00);
      rv_v = 1'b1;
      step(); check("full_pop_req", obs_req, 1'b0); check("full_pop_rv", obs_rv, 2'b01);
      rv_v = 1'b0;
      step(); check("full_resume_req", obs_req, 1'b1); check("full_resume_gnt", obs_gnt, 2'b01);
      drain();

      // Mgr0 read of 0x1000 and mgr1 write of 0x1004, back to back.
      addr_v = {32'h0000_1004, 32'h0000_1000};
      we_v = 2'b10; be_v = '1; wdata_v = {32'hDEAD_BEEF, 32'h0};
      gnt_v = 1'b1;
      req_v = 2'b01; step(); check("rw_gnt0", obs_gnt, 2'b01);
      req_v = 2'b10; step(); check("rw_gnt1", obs_gnt, 2'b10);
      req_v = 2'b00; gnt_v = 1'b0; step();
      rv_v = 1'b1; rdata_v = 32'hCAFE_0001; step();
      check("rw_rv0", obs_rv, 2'b01);
      check("rw_rdata", bus.mgr_rdata_o, 32'hCAFE_0001);
      rv_v = 1'b0; rdata_v = '0; step(); step();
      rv_v = 1'b1; step(); check("rw_rv1", obs_rv, 2'b10);
      idle();

      // Response with nothing outstanding is dropped; traffic continues.
      rv_v = 1'b1; step(); check("empty_rv", obs_rv, 2'b00);
      rv_v = 1'b0; req_v = 2'b01; gnt_v = 1'b1; step(); check("empty_after_gnt", obs_gnt, 2'b01);
      drain();

      // Reset with two transactions in flight.
      req_v = 2'b11; gnt_v = 1'b1; step(); step();
      check("mid_outstanding", m_q.size(), 2);
      apply_reset();
      req_v = 2'b11; gnt_v = 1'b1; step(); check("post_rst_gnt", obs_gnt, 2'b01);
      req_v = 2'b00; gnt_v = 1'b0; rv_v = 1'b1; step(); check("post_rst_rv", obs_rv, 2'b01);
      rv_v = 1'b1; step(); check("post_rst_late_rv", obs_rv, 2'b00);
      idle();

      // Randomized traffic against the model.
      for (int c = 0; c < 500; c++) begin
         req_v = NM'($urandom());
         we_v  = NM'($urandom());
         be_v  = (NM*BW)'($urandom());
         for (int i = 0; i < NM; i++) begin
            addr_v[i*AW +: AW]  = $urandom();
            wdata_v[i*DW +: DW] = $urandom();
         end
`ifdef ZEROHETI_OBI_ARB_LOCK_EN
         for (int i = 0; i < NM; i++) lock_v[i] = ($urandom_range(0, 3) == 0);
`endif
         gnt_v   = ($urandom_range(0, 3) != 0);
         rv_v    = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
         rdata_v = $urandom();
         err_v   = $urandom_range(0, 1);
         step();
      end
      idle();

`ifdef ZEROHETI_OBI_ARB_LOCK_EN
      // Mgr1 holds the lock for three handshakes, then releases it.
      apply_reset();
      req_v = 2'b10; lock_v = 2'b10; gnt_v = 1'b1;
      step(); check("lock_g1", obs_gnt, 2'b10);
      req_v = 2'b11; rv_v = 1'b1;
      step(); check("lock_g2", obs_gnt, 2'b10);
      step(); check("lock_g3", obs_gnt, 2'b10);
      lock_v = 2'b00;
      step(); check("unlock_g", obs_gnt, 2'b10);
      step(); check("after_unlock_g", obs_gnt, 2'b01);
      idle();
      drain();
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
